// File: rtl/motor_driver_ramp_if.sv
// Controller-to-driver bundle: per-wheel commands in, H-bridge pins and status out.
interface motor_driver_ramp_if #(
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned COUNTER_WIDTH = 16
);
    logic [NUM_CH-1:0]               dir;
    logic [NUM_CH*COUNTER_WIDTH-1:0] speed;
    logic [NUM_CH-1:0]               brake;
    logic [2*NUM_CH-1:0]             motor_inputs;
    logic [NUM_CH-1:0]               pwm_en;
    logic [NUM_CH-1:0]               at_speed;

    // Motion controller side
    modport master (
        output dir, speed, brake,
        input  motor_inputs, pwm_en, at_speed
    );

    // Motor driver side
    modport slave (
        input  dir, speed, brake,
        output motor_inputs, pwm_en, at_speed
    );
endinterface

// File: rtl/motor_driver_ramp.sv
// Multi-channel H-bridge driver with soft-start/stop duty ramps, safe reversal
// through a coast interval, and active brake. One shared PWM period counter.
module motor_driver_ramp #(
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned COUNTER_WIDTH = 16,
    parameter int unsigned PERIOD_CYCLES = 50000,
    parameter int unsigned RAMP_STEP     = 500,
    parameter int unsigned DEAD_CYCLES   = 1000
) (
    input  logic               clk,
    input  logic               rst,
    motor_driver_ramp_if.slave bus
);
    localparam int unsigned W  = COUNTER_WIDTH;
    localparam int unsigned WE = COUNTER_WIDTH + 1;
    localparam int unsigned DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    localparam logic [W-1:0]  CNT_LAST   = W'(PERIOD_CYCLES - 1);
    localparam logic [WE-1:0] PERIOD_EXT = WE'(PERIOD_CYCLES);
    localparam logic [W-1:0]  PERIOD_W   = W'(PERIOD_CYCLES);
    localparam logic [W-1:0]  STEP_W     = W'(RAMP_STEP);
    localparam logic [DW-1:0] DEAD_LAST  = DW'(DEAD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_DEAD,
        ST_RUN,
        ST_DECEL,
        ST_BRAKE
    } state_t;

    logic [W-1:0]  cnt;
    logic          wrap;

    state_t        state_q [NUM_CH];
    state_t        state_n [NUM_CH];
    logic [W-1:0]  duty_q  [NUM_CH];
    logic [W-1:0]  duty_n  [NUM_CH];
    logic          adir_q  [NUM_CH];
    logic          adir_n  [NUM_CH];
    logic [DW-1:0] dead_q  [NUM_CH];
    logic [DW-1:0] dead_n  [NUM_CH];

    logic [2*NUM_CH-1:0] mi_n;
    logic [NUM_CH-1:0]   pwm_n;
    logic [NUM_CH-1:0]   at_n;

    logic [W-1:0] spd;
    logic [W-1:0] tgt;
    logic [W-1:0] goal;
    logic [W-1:0] diff;
    logic [W-1:0] step;
    logic [W-1:0] ramped;

    assign wrap = (cnt == CNT_LAST);

    // Shared period counter keeps all channel edges phase-aligned
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

    // Per-channel next state, ramped duty and output values
    always_comb begin
        spd    = '0;
        tgt    = '0;
        goal   = '0;
        diff   = '0;
        step   = '0;
        ramped = '0;
        mi_n   = '0;
        pwm_n  = '0;
        at_n   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_n[i] = state_q[i];
            duty_n[i]  = duty_q[i];
            adir_n[i]  = adir_q[i];
            dead_n[i]  = dead_q[i];

            // Saturate the request at full period; RUN ramps up, DECEL ramps to zero
            spd    = bus.speed[i*W +: W];
            tgt    = ({1'b0, spd} >= PERIOD_EXT) ? PERIOD_W : spd;
            goal   = (state_q[i] == ST_RUN) ? tgt : '0;
            diff   = (goal > duty_q[i]) ? goal - duty_q[i] : duty_q[i] - goal;
            step   = ((RAMP_STEP == 0) || (32'(diff) <= RAMP_STEP)) ? diff : STEP_W;
            ramped = (goal > duty_q[i]) ? duty_q[i] + step : duty_q[i] - step;

            // Duty only moves at the period boundary so no runt pulses appear
            if (wrap) begin
                duty_n[i] = ramped;
            end

            if (bus.brake[i]) begin
                state_n[i] = ST_BRAKE;
                duty_n[i]  = '0;
            end else begin
                unique case (state_q[i])
                    ST_BRAKE: begin
                        state_n[i] = ST_DEAD;
                        dead_n[i]  = '0;
                        duty_n[i]  = '0;
                    end
                    ST_RUN: begin
                        if (bus.dir[i] != adir_q[i]) begin
                            state_n[i] = ST_DECEL;
                        end
                    end
                    ST_DECEL: begin
                        if (bus.dir[i] == adir_q[i]) begin
                            state_n[i] = ST_RUN;
                        end else if (wrap && (duty_q[i] == '0)) begin
                            state_n[i] = ST_DEAD;
                            dead_n[i]  = '0;
                        end
                    end
                    default: begin
                        duty_n[i] = '0;
                        if (dead_q[i] == DEAD_LAST) begin
                            state_n[i] = ST_RUN;
                            adir_n[i]  = bus.dir[i];
                        end else begin
                            dead_n[i] = dead_q[i] + DW'(1);
                        end
                    end
                endcase
            end

            // Outputs follow the state being entered so pins change with the state register
            unique case (state_n[i])
                ST_RUN, ST_DECEL: begin
                    mi_n[2*i +: 2] = adir_n[i] ? 2'b10 : 2'b01;
                    pwm_n[i]       = (cnt < duty_q[i]);
                end
                ST_BRAKE: begin
                    mi_n[2*i +: 2] = 2'b11;
                    pwm_n[i]       = 1'b1;
                end
                default: begin
                    mi_n[2*i +: 2] = 2'b00;
                    pwm_n[i]       = 1'b0;
                end
            endcase
            at_n[i] = (state_n[i] == ST_RUN) && (duty_n[i] == tgt);
        end
    end

    // Channel state and registered pin outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_DEAD;
                duty_q[i]  <= '0;
                adir_q[i]  <= 1'b0;
                dead_q[i]  <= '0;
            end
            bus.motor_inputs <= '0;
            bus.pwm_en       <= '0;
            bus.at_speed     <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_n[i];
                duty_q[i]  <= duty_n[i];
                adir_q[i]  <= adir_n[i];
                dead_q[i]  <= dead_n[i];
            end
            bus.motor_inputs <= mi_n;
            bus.pwm_en       <= pwm_n;
            bus.at_speed     <= at_n;
        end
    end
endmodule

// File: tb/tb_motor_driver_ramp.sv
// Directed bench for motor_driver_ramp: ramp-up, full duty without ramp,
// brake, reversal, reversal abort and mid-run reset.
module tb_motor_driver_ramp;
    logic clk;
    logic rst;
    int   cyc;
    int   vectors;
    int   errors;
    int   pa0, pa1, pb0, pb1;
    logic [1:0] prev_mi [2];
    logic [1:0] cur_mi;

    motor_driver_ramp_if #(.NUM_CH(2), .COUNTER_WIDTH(8)) bus_a ();
    motor_driver_ramp_if #(.NUM_CH(2), .COUNTER_WIDTH(8)) bus_b ();

    motor_driver_ramp #(
        .NUM_CH(2), .COUNTER_WIDTH(8), .PERIOD_CYCLES(100),
        .RAMP_STEP(10), .DEAD_CYCLES(5)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );

    motor_driver_ramp #(
        .NUM_CH(2), .COUNTER_WIDTH(8), .PERIOD_CYCLES(100),
        .RAMP_STEP(0), .DEAD_CYCLES(5)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clocks since reset release; sample n is the negedge after posedge n
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Drive pins must never jump between directions or leave brake straight into drive
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            cur_mi = bus_a.motor_inputs[2*c +: 2];
            if (!rst) begin
                prev_mi[c] = 2'b00;
            end else begin
                if (cur_mi !== prev_mi[c]) begin
                    vectors++;
                    if ((prev_mi[c] == 2'b01 && cur_mi == 2'b10) ||
                        (prev_mi[c] == 2'b10 && cur_mi == 2'b01) ||
                        (prev_mi[c] == 2'b11 && cur_mi != 2'b00)) begin
                        $display("FAIL transition ch%0d: %b -> %b at cycle %0d", c, prev_mi[c], cur_mi, cyc);
                        errors++;
                    end
                end
                prev_mi[c] = cur_mi;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (cyc != n) begin
            $display("FAIL wait_cyc: reached cycle %0d, required %0d", cyc, n);
            errors++;
        end
    endtask

    // Count pwm_en high samples over 100 consecutive samples starting at 'start'
    task automatic measure(input int start);
        wait_cyc(start);
        pa0 = 0; pa1 = 0; pb0 = 0; pb1 = 0;
        for (int k = 0; k < 100; k++) begin
            if (k != 0) @(negedge clk);
            if (bus_a.pwm_en[0] === 1'b1) pa0++;
            if (bus_a.pwm_en[1] === 1'b1) pa1++;
            if (bus_b.pwm_en[0] === 1'b1) pb0++;
            if (bus_b.pwm_en[1] === 1'b1) pb1++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++; if (bus_a.motor_inputs !== 4'b0000) begin $display("FAIL reset_mi_a: got %b, expected 0000", bus_a.motor_inputs); errors++; end
        vectors++; if (bus_a.pwm_en !== 2'b00) begin $display("FAIL reset_pwm_a: got %b, expected 00", bus_a.pwm_en); errors++; end
        vectors++; if (bus_a.at_speed !== 2'b00) begin $display("FAIL reset_at_a: got %b, expected 00", bus_a.at_speed); errors++; end
        vectors++; if (bus_b.motor_inputs !== 4'b0000) begin $display("FAIL reset_mi_b: got %b, expected 0000", bus_b.motor_inputs); errors++; end
        vectors++; if (bus_b.pwm_en !== 2'b00) begin $display("FAIL reset_pwm_b: got %b, expected 00", bus_b.pwm_en); errors++; end
    endtask

    task automatic test_startup();
        logic [1:0] e;
        int e0, e1;
        rst = 1'b1;
        for (int n = 0; n <= 5; n++) begin
            wait_cyc(n);
            e = (n < 5) ? 2'b00 : 2'b01;
            vectors++; if (bus_a.motor_inputs[1:0] !== e) begin $display("FAIL start_mi0 n=%0d: got %b, expected %b", n, bus_a.motor_inputs[1:0], e); errors++; end
            vectors++; if (bus_a.motor_inputs[3:2] !== e) begin $display("FAIL start_mi1 n=%0d: got %b, expected %b", n, bus_a.motor_inputs[3:2], e); errors++; end
        end
        for (int p = 1; p <= 7; p++) begin
            measure(100 * p + 1);
            e0 = (10 * p < 50) ? 10 * p : 50;
            e1 = (10 * p < 70) ? 10 * p : 70;
            vectors++; if (pa0 != e0) begin $display("FAIL ramp_ch0 p=%0d: got %0d, expected %0d", p, pa0, e0); errors++; end
            vectors++; if (pa1 != e1) begin $display("FAIL ramp_ch1 p=%0d: got %0d, expected %0d", p, pa1, e1); errors++; end
            vectors++; if (pb0 != 100) begin $display("FAIL full_duty_ch0 p=%0d: got %0d, expected 100", p, pb0); errors++; end
            vectors++; if (pb1 != 70) begin $display("FAIL jump_ch1 p=%0d: got %0d, expected 70", p, pb1); errors++; end
            if (p == 3) begin
                vectors++; if (bus_a.at_speed[0] !== 1'b0) begin $display("FAIL at_speed_early: got %b, expected 0", bus_a.at_speed[0]); errors++; end
            end
            if (p == 4) begin
                vectors++; if (bus_a.at_speed[0] !== 1'b1) begin $display("FAIL at_speed_reached: got %b, expected 1", bus_a.at_speed[0]); errors++; end
            end
        end
    endtask

    task automatic test_brake();
        logic [1:0] e;
        wait_cyc(850);
        vectors++; if (bus_a.at_speed[1] !== 1'b1) begin $display("FAIL brake_pre_at1: got %b, expected 1", bus_a.at_speed[1]); errors++; end
        bus_a.brake[1] = 1'b1;
        wait_cyc(851);
        vectors++; if (bus_a.motor_inputs[3:2] !== 2'b11) begin $display("FAIL brake_mi1: got %b, expected 11", bus_a.motor_inputs[3:2]); errors++; end
        vectors++; if (bus_a.pwm_en[1] !== 1'b1) begin $display("FAIL brake_pwm1: got %b, expected 1", bus_a.pwm_en[1]); errors++; end
        vectors++; if (bus_a.at_speed[1] !== 1'b0) begin $display("FAIL brake_at1: got %b, expected 0", bus_a.at_speed[1]); errors++; end
        vectors++; if (bus_a.motor_inputs[1:0] !== 2'b01) begin $display("FAIL brake_mi0: got %b, expected 01", bus_a.motor_inputs[1:0]); errors++; end
        vectors++; if (bus_a.at_speed[0] !== 1'b1) begin $display("FAIL brake_at0: got %b, expected 1", bus_a.at_speed[0]); errors++; end
        wait_cyc(855);
        vectors++; if (bus_a.pwm_en[1] !== 1'b1) begin $display("FAIL brake_hold_pwm1: got %b, expected 1", bus_a.pwm_en[1]); errors++; end
        wait_cyc(860);
        bus_a.brake[1] = 1'b0;
        for (int n = 861; n <= 866; n++) begin
            wait_cyc(n);
            e = (n < 866) ? 2'b00 : 2'b01;
            vectors++; if (bus_a.motor_inputs[3:2] !== e) begin $display("FAIL release_mi1 n=%0d: got %b, expected %b", n, bus_a.motor_inputs[3:2], e); errors++; end
            vectors++; if (bus_a.pwm_en[1] !== 1'b0) begin $display("FAIL release_pwm1 n=%0d: got %b, expected 0", n, bus_a.pwm_en[1]); errors++; end
        end
        measure(901);
        vectors++; if (pa1 != 10) begin $display("FAIL release_ramp1: got %0d, expected 10", pa1); errors++; end
        vectors++; if (pa0 != 50) begin $display("FAIL brake_ch0_duty: got %0d, expected 50", pa0); errors++; end
    endtask

    task automatic test_reversal();
        logic [1:0] e;
        wait_cyc(1000);
        bus_a.dir[0] = 1'b1;
        wait_cyc(1001);
        vectors++; if (bus_a.motor_inputs[1:0] !== 2'b01) begin $display("FAIL decel_mi0: got %b, expected 01", bus_a.motor_inputs[1:0]); errors++; end
        vectors++; if (bus_a.at_speed[0] !== 1'b0) begin $display("FAIL decel_at0: got %b, expected 0", bus_a.at_speed[0]); errors++; end
        for (int p = 0; p <= 5; p++) begin
            measure(1001 + 100 * p);
            vectors++; if (pa0 != 50 - 10 * p) begin $display("FAIL decel_duty p=%0d: got %0d, expected %0d", p, pa0, 50 - 10 * p); errors++; end
        end
        for (int n = 1600; n <= 1605; n++) begin
            wait_cyc(n);
            e = (n < 1605) ? 2'b00 : 2'b10;
            vectors++; if (bus_a.motor_inputs[1:0] !== e) begin $display("FAIL reverse_mi0 n=%0d: got %b, expected %b", n, bus_a.motor_inputs[1:0], e); errors++; end
        end
        measure(1701);
        vectors++; if (pa0 != 10) begin $display("FAIL reverse_ramp0: got %0d, expected 10", pa0); errors++; end
        vectors++; if (pa1 != 70) begin $display("FAIL reverse_ch1_duty: got %0d, expected 70", pa1); errors++; end
    endtask

    task automatic test_abort();
        wait_cyc(2100);
        bus_a.dir[0] = 1'b0;
        measure(2201);
        vectors++; if (pa0 != 40) begin $display("FAIL abort_decel: got %0d, expected 40", pa0); errors++; end
        wait_cyc(2350);
        bus_a.dir[0] = 1'b1;
        wait_cyc(2351);
        vectors++; if (bus_a.motor_inputs[1:0] !== 2'b10) begin $display("FAIL abort_mi0: got %b, expected 10", bus_a.motor_inputs[1:0]); errors++; end
        vectors++; if (bus_a.at_speed[0] !== 1'b0) begin $display("FAIL abort_at0: got %b, expected 0", bus_a.at_speed[0]); errors++; end
        measure(2401);
        vectors++; if (pa0 != 40) begin $display("FAIL abort_rise1: got %0d, expected 40", pa0); errors++; end
        measure(2501);
        vectors++; if (pa0 != 50) begin $display("FAIL abort_rise2: got %0d, expected 50", pa0); errors++; end
        vectors++; if (bus_a.at_speed[0] !== 1'b1) begin $display("FAIL abort_at_speed: got %b, expected 1", bus_a.at_speed[0]); errors++; end
    endtask

    task automatic test_reset_mid();
        logic [1:0] e0, e1;
        bus_a.speed = {8'd90, 8'd80};
        wait_cyc(2750);
        #2 rst = 1'b0;
        #1;
        vectors++; if (bus_a.motor_inputs !== 4'b0000) begin $display("FAIL midrst_mi_a: got %b, expected 0000", bus_a.motor_inputs); errors++; end
        vectors++; if (bus_a.pwm_en !== 2'b00) begin $display("FAIL midrst_pwm_a: got %b, expected 00", bus_a.pwm_en); errors++; end
        vectors++; if (bus_a.at_speed !== 2'b00) begin $display("FAIL midrst_at_a: got %b, expected 00", bus_a.at_speed); errors++; end
        vectors++; if (bus_b.motor_inputs !== 4'b0000) begin $display("FAIL midrst_mi_b: got %b, expected 0000", bus_b.motor_inputs); errors++; end
        vectors++; if (bus_b.pwm_en !== 2'b00) begin $display("FAIL midrst_pwm_b: got %b, expected 00", bus_b.pwm_en); errors++; end
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n <= 5; n++) begin
            wait_cyc(n);
            e0 = (n < 5) ? 2'b00 : 2'b10;
            e1 = (n < 5) ? 2'b00 : 2'b01;
            vectors++; if (bus_a.motor_inputs[1:0] !== e0) begin $display("FAIL restart_mi0 n=%0d: got %b, expected %b", n, bus_a.motor_inputs[1:0], e0); errors++; end
            vectors++; if (bus_a.motor_inputs[3:2] !== e1) begin $display("FAIL restart_mi1 n=%0d: got %b, expected %b", n, bus_a.motor_inputs[3:2], e1); errors++; end
        end
        for (int p = 1; p <= 2; p++) begin
            measure(100 * p + 1);
            vectors++; if (pa0 != 10 * p) begin $display("FAIL restart_ramp0 p=%0d: got %0d, expected %0d", p, pa0, 10 * p); errors++; end
            vectors++; if (pa1 != 10 * p) begin $display("FAIL restart_ramp1 p=%0d: got %0d, expected %0d", p, pa1, 10 * p); errors++; end
            vectors++; if (pb0 != 100) begin $display("FAIL restart_full p=%0d: got %0d, expected 100", p, pb0); errors++; end
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst     = 1'b0;
        bus_a.dir   = 2'b00;
        bus_a.speed = {8'd70, 8'd50};
        bus_a.brake = 2'b00;
        bus_b.dir   = 2'b00;
        bus_b.speed = {8'd70, 8'd255};
        bus_b.brake = 2'b00;

        test_reset();
        test_startup();
        test_brake();
        test_reversal();
        test_abort();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/motor_driver_ramp.md
# motor_driver_ramp

Multi-channel H-bridge motor driver: the next generation of the single-channel direction/PWM driver. It adds per-channel soft-start/soft-stop duty ramping, safe direction reversal (decelerate, dead-time, re-energise), and an active brake. It sits between the robot's motion controller, which supplies target speed, direction and brake per wheel, and the H-bridge pins. All channels share one PWM period counter, so their edges stay phase-aligned.

## Interface
- NUM_CH, 2, number of motor channels
- COUNTER_WIDTH, 16, width of period counter, speed and duty values
- PERIOD_CYCLES, 50000, PWM period in clk cycles; must satisfy 2 ≤ PERIOD_CYCLES ≤ 2^COUNTER_WIDTH
- RAMP_STEP, 500, maximum duty change per PWM period; 0 means the duty jumps straight to target
- DEAD_CYCLES, 1000, coast time in clk cycles before energising in a new direction; ≥ 1

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- dir  in  NUM_CH  requested direction per channel (bit i = channel i)
- speed  in  NUM_CH*COUNTER_WIDTH  target duty per channel; channel i at bits [i*W +: W]
- brake  in  NUM_CH  active brake request per channel
- motor_inputs  out  2*NUM_CH  H-bridge inputs; channel i at bits [2i+1:2i]
- pwm_en  out  NUM_CH  H-bridge enable (PWM) per channel
- at_speed  out  NUM_CH  channel is in RUN and its current duty equals its effective target

## Operation
- Shared counter `cnt` runs 0..PERIOD_CYCLES-1 and wraps to 0. A wrap event is the cycle in which cnt == PERIOD_CYCLES-1.
- Effective target: tgt = min(speed_i, PERIOD_CYCLES). A value ≥ PERIOD_CYCLES gives 100 % duty; 0 gives 0 %.
- Per-channel registers: cur_duty (W bits), adir (applied direction), state, dead counter.
- PWM: pwm_en_i is registered as (cnt < cur_duty) when in RUN or DECEL, 1 in BRAKE, and 0 in DEAD.
- Direction encoding: adir = 0 gives motor_inputs 2'b01; adir = 1 gives 2'b10. DEAD gives 2'b00. BRAKE gives 2'b11.
- cur_duty changes only on a wrap event, so no runt pulses occur. It moves toward its goal by min(RAMP_STEP, |goal - cur_duty|). With RAMP_STEP = 0 it sets cur_duty = goal. The goal is tgt in RUN and 0 in DECEL.
- States and transitions, evaluated every cycle, with brake highest priority:
  - any state, brake_i = 1 → BRAKE. cur_duty is forced to 0 immediately.
  - BRAKE, brake_i = 0 → DEAD, with the dead counter cleared.
  - RUN, dir_i ≠ adir → DECEL.
  - DECEL, dir_i == adir → RUN (reversal aborted, ramp resumes from the current duty).
  - DECEL, wrap event with cur_duty == 0 → DEAD, with the dead counter cleared.
  - DEAD, dead counter reaches DEAD_CYCLES-1 → RUN, latching adir ← dir_i. cur_duty is 0 at entry and ramps from there.
- Changing speed in RUN only retargets the ramp; it causes no state change.
- at_speed_i = (state == RUN) && (cur_duty == tgt), registered.

## Timing
- Reset, asynchronous: cnt = 0, all channels in DEAD with dead counter 0, cur_duty = 0, adir = 0. Outputs are motor_inputs = 0, pwm_en = 0, at_speed = 0.
- After reset release, channel i enters RUN DEAD_CYCLES clocks later. motor_inputs updates in the same cycle the state register changes.
- All outputs are registered. pwm_en reflects the cnt value with 1 cycle of latency. At the first cycle with cnt = 0 after a wrap, the new duty is in effect.
- Brake takes effect on motor_inputs and pwm_en 1 cycle after brake_i is sampled high, regardless of the ramp phase.
- Ramp time from 0 to tgt is ceil(tgt / RAMP_STEP) PWM periods.
- A reversal from duty D takes ceil(D / RAMP_STEP) periods, plus alignment to the next wrap, plus DEAD_CYCLES, before the opposite drive appears.
- motor_inputs never switches directly between 2'b01 and 2'b10, nor between either of those and 2'b11 except through BRAKE entry. A DEAD interval always precedes a new drive direction.
- Reset asserted mid-operation immediately forces the reset values on every channel.

## Test plan
Bench parameters: NUM_CH = 2, COUNTER_WIDTH = 8, PERIOD_CYCLES = 100, RAMP_STEP = 10, DEAD_CYCLES = 5.
- Reset release with dir = 0, speed0 = 50: motor_inputs[1:0] is 00 for 5 clocks, then 01. Duty rises 10, 20, …, 50 over 5 periods, with pwm_en high exactly cur_duty cycles per period. at_speed0 rises once duty = 50.
- speed0 = 255, RAMP_STEP = 0 variant: 100 % duty (pwm_en held high) from the first period in RUN.
- In RUN at duty 50, toggle dir0: duty ramps 40 … 0, then motor_inputs = 00 for 5 cycles, then 10, and the ramp restarts from 0. 01 and 10 are never adjacent.
- Toggle dir0 back during DECEL at duty 30: state returns to RUN with adir unchanged, and duty ramps back up from 30.
- Assert brake1 mid-period at duty 70: one cycle later motor_inputs[3:2] = 11 and pwm_en1 = 1. Channel 0 is unaffected. On release: 00 for 5 cycles, then RUN from duty 0.
- Assert rst mid-ramp on both channels: all outputs 0 immediately. After release, the full DEAD-then-ramp sequence repeats.
